// File: rtl/stack_alu_if.sv
// Token handshake and status bus between the token sources/display consumers and the RPN core.
interface stack_alu_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             clear;
  logic             tok_valid;
  logic             tok_ready;
  logic             tok_kind;
  logic [2:0]       tok_op;
  logic [WIDTH-1:0] tok_data;
  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             err;
  logic [2:0]       err_code;

  modport master (
    output clear, tok_valid, tok_kind, tok_op, tok_data,
    input  tok_ready, top, depth, busy, result, result_valid, err, err_code
  );

  modport slave (
    input  clear, tok_valid, tok_kind, tok_op, tok_data,
    output tok_ready, top, depth, busy, result, result_valid, err, err_code
  );
endinterface

// File: rtl/stack_alu_core.sv
// RPN evaluation core: signed operand stack with arithmetic/stack ops,
// multi-cycle restoring division and sticky error reporting.
//
// state | meaning
// IDLE  | accepting tokens
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | apply quotient sign, pop two, push quotient
module stack_alu_core #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  stack_alu_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(WIDTH);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_TWO  = DW'(2);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;
  localparam logic [2:0] OP_DUP = 3'd5;
  localparam logic [2:0] OP_SWP = 3'd6;
  localparam logic [2:0] OP_EQU = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Entry 0 is TOS, entry 1 is NOS; pushes shift toward higher indices.
  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [DW-1:0]    r_depth;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_err;
  logic [2:0]       r_err_code;

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dsr;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic [2:0]       w_chk;
  logic             w_div_start;
  logic [WIDTH-1:0] w_tos;
  logic [WIDTH-1:0] w_nos;
  logic [WIDTH-1:0] w_tos_mag;
  logic [WIDTH-1:0] w_nos_mag;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_quot;

  assign bus.tok_ready    = (r_state == S_IDLE) && !bus.clear;
  assign bus.top          = (r_depth == '0) ? '0 : r_stack[0];
  assign bus.depth        = r_depth;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.err          = r_err;
  assign bus.err_code     = r_err_code;

  assign w_accept  = bus.tok_valid && bus.tok_ready;
  assign w_tos     = r_stack[0];
  assign w_nos     = r_stack[1];
  assign w_tos_mag = w_tos[WIDTH-1] ? -w_tos : w_tos;
  assign w_nos_mag = w_nos[WIDTH-1] ? -w_nos : w_nos;
  assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dsr};
  assign w_quot    = r_neg ? -r_quo : r_quo;
  assign w_div_start = w_accept && !r_err && bus.tok_kind &&
                       (bus.tok_op == OP_DIV) && (w_chk == 3'd0);

  // Precondition check for the presented token; underflow is tested first so it wins.
  always_comb begin
    w_chk = 3'd0;
    if (!bus.tok_kind) begin
      if (r_depth == DEPTH_FULL) w_chk = 3'd2;
    end else begin
      case (bus.tok_op)
        OP_ADD, OP_SUB, OP_MUL, OP_SWP: if (r_depth < DEPTH_TWO) w_chk = 3'd1;
        OP_DIV: begin
          if (r_depth < DEPTH_TWO) w_chk = 3'd1;
          else if (w_tos == '0)    w_chk = 3'd3;
        end
        OP_NEG: if (r_depth == '0) w_chk = 3'd1;
        OP_DUP: begin
          if (r_depth == '0)              w_chk = 3'd1;
          else if (r_depth == DEPTH_FULL) w_chk = 3'd2;
        end
        default: begin
          if (r_depth == '0)            w_chk = 3'd1;
          else if (r_depth != DW'(1))   w_chk = 3'd4;
        end
      endcase
    end
  end

  // Result of the two-operand arithmetic ops (wraps modulo 2^WIDTH).
  always_comb begin
    w_bin = w_nos + w_tos;
    case (bus.tok_op)
      OP_SUB:  w_bin = w_nos - w_tos;
      OP_MUL:  w_bin = w_nos * w_tos;
      default: w_bin = w_nos + w_tos;
    endcase
  end

  // Next-state logic; clear aborts any division.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_div_start) w_state_nxt = S_DIV;
      S_DIV:   if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.clear) w_state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Stack, result, error and divider datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
      r_depth        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_err_code     <= 3'd0;
      r_quo          <= '0;
      r_rem          <= '0;
      r_dsr          <= '0;
      r_neg          <= 1'b0;
      r_cnt          <= '0;
    end else if (bus.clear) begin
      r_depth        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
      r_err_code     <= 3'd0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !r_err) begin
            if (w_chk != 3'd0) begin
              r_err      <= 1'b1;
              r_err_code <= w_chk;
            end else if (!bus.tok_kind) begin
              for (int i = DEPTH - 1; i > 0; i--) r_stack[i] <= r_stack[i-1];
              r_stack[0] <= bus.tok_data;
              r_depth    <= r_depth + DW'(1);
            end else begin
              case (bus.tok_op)
                OP_ADD, OP_SUB, OP_MUL: begin
                  for (int i = 1; i < DEPTH - 1; i++) r_stack[i] <= r_stack[i+1];
                  r_stack[0] <= w_bin;
                  r_depth    <= r_depth - DW'(1);
                end
                OP_DIV: begin
                  r_quo <= w_nos_mag;
                  r_dsr <= w_tos_mag;
                  r_rem <= '0;
                  r_neg <= w_nos[WIDTH-1] ^ w_tos[WIDTH-1];
                  r_cnt <= CW'(WIDTH - 1);
                end
                OP_NEG: r_stack[0] <= -w_tos;
                OP_DUP: begin
                  for (int i = DEPTH - 1; i > 0; i--) r_stack[i] <= r_stack[i-1];
                  r_depth <= r_depth + DW'(1);
                end
                OP_SWP: begin
                  r_stack[0] <= w_nos;
                  r_stack[1] <= w_tos;
                end
                default: begin
                  r_result       <= w_tos;
                  r_result_valid <= 1'b1;
                  r_depth        <= '0;
                end
              endcase
            end
          end
        end
        S_DIV: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          for (int i = 1; i < DEPTH - 1; i++) r_stack[i] <= r_stack[i+1];
          r_stack[0] <= w_quot;
          r_depth    <= r_depth - DW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_alu_core.sv
// Directed-vector bench for the RPN core with hand-computed expectations.
module tb_stack_alu_core;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_NEG = 3'd4;
  localparam logic [2:0] OP_DUP = 3'd5;
  localparam logic [2:0] OP_SWP = 3'd6;
  localparam logic [2:0] OP_EQU = 3'd7;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  stack_alu_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack_alu_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] val);
    bus.tok_valid = 1'b1;
    bus.tok_kind  = 1'b0;
    bus.tok_op    = 3'd7;
    bus.tok_data  = val;
    tick();
    bus.tok_valid = 1'b0;
  endtask

  task automatic op(input logic [2:0] code);
    bus.tok_valid = 1'b1;
    bus.tok_kind  = 1'b1;
    bus.tok_op    = code;
    bus.tok_data  = '0;
    tick();
    bus.tok_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  initial begin
    int cnt;
    int busy_seen;
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.tok_valid = 1'b0;
    bus.tok_kind  = 1'b0;
    bus.tok_op    = 3'd0;
    bus.tok_data  = '0;
    tick();
    tick();
    check("rst_depth", 32'(bus.depth), 32'd0);
    check("rst_top", bus.top, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_rv", 32'(bus.result_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_code", 32'(bus.err_code), 32'd0);
    check("rst_ready", 32'(bus.tok_ready), 32'd1);
    rst_n = 1'b1;

    // 3 4 + =
    push(32'd3);
    push(32'd4);
    op(OP_ADD);
    check("add_top", bus.top, 32'd7);
    check("add_depth", 32'(bus.depth), 32'd1);
    op(OP_EQU);
    check("eq_result", bus.result, 32'd7);
    check("eq_rv", 32'(bus.result_valid), 32'd1);
    check("eq_depth", 32'(bus.depth), 32'd0);
    check("eq_top", bus.top, 32'd0);
    check("eq_err", 32'(bus.err), 32'd0);
    tick();
    check("eq_rv_pulse", 32'(bus.result_valid), 32'd0);
    check("eq_result_hold", bus.result, 32'd7);

    // -20 / 6 = -3 with busy for WIDTH+1 cycles
    push(32'hFFFF_FFEC);
    push(32'd6);
    op(OP_DIV);
    check("div_hold_top", bus.top, 32'd6);
    check("div_hold_depth", 32'(bus.depth), 32'd2);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      if (bus.tok_ready) check("div_ready_low", 32'(bus.tok_ready), 32'd0);
      tick();
    end
    check("div_busy_cycles", 32'(cnt), 32'd33);
    check("div_ready_after", 32'(bus.tok_ready), 32'd1);
    check("div_top", bus.top, 32'hFFFF_FFFD);
    check("div_depth", 32'(bus.depth), 32'd1);
    do_clear();

    // SUB, DUP, MUL, NEG, SWAP, ADD, EQUAL
    push(32'd7);
    push(32'd3);
    op(OP_SUB);
    check("sub_top", bus.top, 32'd4);
    op(OP_DUP);
    check("dup_depth", 32'(bus.depth), 32'd2);
    op(OP_MUL);
    check("mul_top", bus.top, 32'd16);
    op(OP_NEG);
    check("neg_top", bus.top, 32'hFFFF_FFF0);
    push(32'd5);
    op(OP_SWP);
    check("swap_top", bus.top, 32'hFFFF_FFF0);
    op(OP_SUB);
    check("swap_sub_top", bus.top, 32'd21);
    op(OP_EQU);
    check("chain_result", bus.result, 32'd21);
    do_clear();

    // MIN / -1 = MIN
    push(32'h8000_0000);
    push(32'hFFFF_FFFF);
    op(OP_DIV);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      tick();
    end
    check("min_div_top", bus.top, 32'h8000_0000);
    check("min_div_depth", 32'(bus.depth), 32'd1);
    do_clear();

    // overflow on 9th push, sticky discard, clear
    for (int i = 1; i <= 8; i++) push(32'(i));
    push(32'd9);
    check("ovf_err", 32'(bus.err), 32'd1);
    check("ovf_code", 32'(bus.err_code), 32'd2);
    check("ovf_depth", 32'(bus.depth), 32'd8);
    check("ovf_top", bus.top, 32'd8);
    op(OP_ADD);
    check("sticky_depth", 32'(bus.depth), 32'd8);
    check("sticky_code", 32'(bus.err_code), 32'd2);
    bus.clear     = 1'b1;
    bus.tok_valid = 1'b1;
    bus.tok_kind  = 1'b0;
    bus.tok_data  = 32'd42;
    #1;
    check("clear_ready", 32'(bus.tok_ready), 32'd0);
    tick();
    bus.clear     = 1'b0;
    bus.tok_valid = 1'b0;
    check("clr_depth", 32'(bus.depth), 32'd0);
    check("clr_err", 32'(bus.err), 32'd0);
    check("clr_top", bus.top, 32'd0);
    check("clr_code", 32'(bus.err_code), 32'd0);
    check("clr_result", bus.result, 32'd0);

    // divide by zero
    push(32'd5);
    push(32'd0);
    op(OP_DIV);
    check("dz_code", 32'(bus.err_code), 32'd3);
    check("dz_depth", 32'(bus.depth), 32'd2);
    check("dz_top", bus.top, 32'd0);
    busy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.busy) busy_seen = 1;
      tick();
    end
    check("dz_no_busy", 32'(busy_seen), 32'd0);
    do_clear();

    // underflow, then unbalanced EQUAL
    push(32'd2);
    op(OP_ADD);
    check("uf_code", 32'(bus.err_code), 32'd1);
    check("uf_depth", 32'(bus.depth), 32'd1);
    check("uf_top", bus.top, 32'd2);
    do_clear();
    push(32'd1);
    push(32'd2);
    op(OP_EQU);
    check("unbal_code", 32'(bus.err_code), 32'd4);
    check("unbal_rv", 32'(bus.result_valid), 32'd0);
    check("unbal_depth", 32'(bus.depth), 32'd2);
    do_clear();

    // async reset mid-division
    push(32'h8000_0000);
    push(32'hFFFF_FFFF);
    op(OP_DIV);
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_depth", 32'(bus.depth), 32'd0);
    check("ar_top", bus.top, 32'd0);
    check("ar_ready", 32'(bus.tok_ready), 32'd1);
    check("ar_err", 32'(bus.err), 32'd0);
    tick();
    rst_n = 1'b1;
    push(32'd9);
    check("post_rst_top", bus.top, 32'd9);
    check("post_rst_depth", 32'(bus.depth), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
